// File: rtl/arb_pkg.sv
// Purpose : shared constants and state encoding for the 4-way round-robin arbiter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_arbiter_4_if.sv
// Purpose : request/grant bundle between the four requester FSMs and the arbiter.
// Latency : n/a (wires only).
// Backpressure: grant is the only flow control; a requester proceeds only while it owns gnt.
// Ports (master = requester side, slave = arbiter side):
//   req[3:0], done          : requester -> arbiter
//   gnt[3:0], gnt_id[1:0],
//   busy, timeout           : arbiter -> requesters / datapath select
interface rr_arbiter_4_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             busy;
    logic             timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, busy, timeout
    );

endinterface : rr_arbiter_4_if

// File: rtl/rr_pick.sv
// Purpose : combinational round-robin pick: first set request at or after ptr, wrapping 3->0.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; result is only meaningful when any=1.
// Ports: req[3:0], ptr[1:0] in; id[1:0] (winner), any (some request set) out.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  off;

    always_comb begin
        // Rotate so that requester ptr lands at bit 0; the 2-bit index add wraps mod 4.
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[ID_W'(i) + ptr];
        end

        // Fixed priority on the rotated vector: lowest set bit wins.
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ID_W'(i);
            end
        end

        // Rotate the winning offset back into an absolute requester index.
        id  = off + ptr;
        any = |req;
    end

endmodule : rr_pick

// File: rtl/rr_arbiter_4.sv
// Purpose : 4-requester round-robin arbiter with registered one-hot grant and hold limit.
// Latency : 1 edge from request to grant; 1 dead cycle (RELEASE) between consecutive grants.
// Backpressure: owner keeps gnt until done, request drop, or MAX_HOLD cycles; others wait.
// Ports: clk, rst_n (async active-low); arb (slave modport): req, done in;
//        gnt, gnt_id, busy, timeout out (all registered).
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter_4_if.slave  arb
);

    // Last counter value of a grant when the limit is enabled.
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q,   state_d;
    logic [N_REQ-1:0]  gnt_q,     gnt_d;
    logic [ID_W-1:0]   gnt_id_q,  gnt_id_d;
    logic              busy_q,    busy_d;
    logic              timeout_q, timeout_d;
    logic [ID_W-1:0]   ptr_q,     ptr_d;
    logic [HOLD_W-1:0] cnt_q,     cnt_d;

    logic [ID_W-1:0]   pick_id;
    logic              pick_any;
    logic              hold_hit;
    logic              owner_req;

    rr_pick u_pick (
        .req (arb.req),
        .ptr (ptr_q),
        .id  (pick_id),
        .any (pick_any)
    );

    assign hold_hit  = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    assign owner_req = arb.req[gnt_id_q];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;           // pulse lasts only for the RELEASE-entry cycle
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE, RELEASE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (pick_any) begin
                    state_d  = GRANT;
                    gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
                    gnt_id_d = pick_id;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                end else begin
                    state_d  = IDLE;
                end
            end

            GRANT: begin
                // Saturate so that an unlimited hold cannot wrap the counter.
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (arb.done || !owner_req || hold_hit) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ptr_d     = gnt_id_q + 1'b1;
                    // Timeout is reported only when neither done nor withdrawal explains the exit.
                    timeout_d = !arb.done && owner_req;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign arb.gnt     = gnt_q;
    assign arb.gnt_id  = gnt_id_q;
    assign arb.busy    = busy_q;
    assign arb.timeout = timeout_q;

endmodule : rr_arbiter_4
